// File: rtl/ysyx_22040632_mul_pkg.sv
// ysyx_22040632_mul_pkg: shared constants for the iterative multiplier
package ysyx_22040632_mul_pkg;
  localparam int XLEN = 64;
  localparam int WXLEN = 32;
  localparam int N64 = 65;
  localparam int N32 = 33;
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] BUSY = 2'd1;
  localparam logic [1:0] DONE = 2'd2;
  localparam logic [1:0] MUL_SS = 2'b11;
  localparam logic [1:0] MUL_SU = 2'b10;
  localparam logic [1:0] MUL_UU = 2'b00;
endpackage

// File: rtl/ysyx_22040632_mul_if.sv
// ysyx_22040632_mul_if: EXU <-> multiplier request/response channel
interface ysyx_22040632_mul_if #(parameter int XLEN = ysyx_22040632_mul_pkg::XLEN);
  logic mul_valid;
  logic flush;
  logic mulw;
  logic [1:0] mul_signed;
  logic [XLEN-1:0] multiplicand;
  logic [XLEN-1:0] multiplier;
  logic mul_ready;
  logic out_valid;
  logic [XLEN-1:0] result_hi;
  logic [XLEN-1:0] result_lo;
  modport master (output mul_valid, flush, mulw, mul_signed, multiplicand, multiplier,
                  input mul_ready, out_valid, result_hi, result_lo);
  modport slave (input mul_valid, flush, mulw, mul_signed, multiplicand, multiplier,
                 output mul_ready, out_valid, result_hi, result_lo);
endinterface

// File: rtl/ysyx_22040632_mul_opext.sv
// ysyx_22040632_mul_opext: extend an operand to XLEN+1 bits (mulw uses the low WXLEN bits)
module ysyx_22040632_mul_opext #(parameter int XLEN = 64, parameter int WXLEN = 32) (
  input  logic [XLEN-1:0] op,
  input  logic            mulw,
  input  logic            sgn,
  output logic [XLEN:0]   ext
);
  always_comb ext = mulw ? {{(XLEN-WXLEN+1){sgn & op[WXLEN-1]}}, op[WXLEN-1:0]} : {sgn & op[XLEN-1], op};
endmodule

// File: rtl/ysyx_22040632_mul_iter.sv
// ysyx_22040632_mul_iter: radix-2 shift-add multiplier, 64x64 or 32x32 (mulw), flushable
module ysyx_22040632_mul_iter
  import ysyx_22040632_mul_pkg::*;
#(parameter int XLEN = 64, parameter int WXLEN = 32) (
  input logic clk,
  input logic rst_n,
  ysyx_22040632_mul_if.slave bus
);
  logic [1:0] state_q, state_d;
  logic [6:0] cnt_q, cnt_d;
  logic mulw_q, mulw_d;
  logic [XLEN+1:0] acc_q, acc_d, addend, sum;
  logic [XLEN:0] mcand_q, mcand_d, mpr_q, mpr_d, a_ext, b_ext;
  logic [XLEN-1:0] hi_q, hi_d, lo_q, lo_d;
  logic accept, busy, last, done_in;
  ysyx_22040632_mul_opext #(.XLEN(XLEN), .WXLEN(WXLEN)) u_ext_a (
    .op(bus.multiplicand), .mulw(bus.mulw), .sgn(bus.mul_signed[1]), .ext(a_ext));
  ysyx_22040632_mul_opext #(.XLEN(XLEN), .WXLEN(WXLEN)) u_ext_b (
    .op(bus.multiplier), .mulw(bus.mulw), .sgn(bus.mul_signed == MUL_SS), .ext(b_ext));
  // the multiplier sign bit has negative weight, so the final step subtracts
  always_comb begin
    accept = bus.mul_valid && bus.mul_ready && !bus.flush;
    busy = state_q == BUSY;
    last = cnt_q == '0;
    addend = mpr_q[0] ? {mcand_q[XLEN], mcand_q} : '0;
    sum = last ? acc_q - addend : acc_q + addend;
    state_d = bus.flush ? IDLE : accept ? BUSY : busy ? (last ? DONE : BUSY) : IDLE;
    cnt_d = accept ? (bus.mulw ? 7'(N32-1) : 7'(N64-1)) : (busy && !last) ? cnt_q - 7'd1 : cnt_q;
    acc_d = accept ? '0 : busy ? {sum[XLEN+1], sum[XLEN+1:1]} : acc_q;
    mpr_d = accept ? b_ext : busy ? {sum[0], mpr_q[XLEN:1]} : mpr_q;
    mcand_d = accept ? a_ext : mcand_q;
    mulw_d = accept ? bus.mulw : mulw_q;
    done_in = busy && last && !bus.flush;
    hi_d = done_in ? (mulw_q ? '0 : {acc_d[XLEN-2:0], mpr_d[XLEN]}) : hi_q;
    lo_d = done_in ? (mulw_q ? {{(XLEN-WXLEN){mpr_d[XLEN-1]}}, mpr_d[XLEN-1 -: WXLEN]} : mpr_d[XLEN-1:0]) : lo_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q <= '0;
      mulw_q <= 1'b0;
      acc_q <= '0;
      mcand_q <= '0;
      mpr_q <= '0;
      hi_q <= '0;
      lo_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      mulw_q <= mulw_d;
      acc_q <= acc_d;
      mcand_q <= mcand_d;
      mpr_q <= mpr_d;
      hi_q <= hi_d;
      lo_q <= lo_d;
    end
  end
  assign bus.mul_ready = (state_q == IDLE || state_q == DONE) && rst_n;
  assign bus.out_valid = state_q == DONE;
  assign bus.result_hi = hi_q;
  assign bus.result_lo = lo_q;
endmodule

// File: tb/tb_ysyx_22040632_mul_iter.sv
// tb_ysyx_22040632_mul_iter: directed vectors for the iterative multiplier
module tb_ysyx_22040632_mul_iter;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int checks = 0;
  int failures = 0;
  always #5 clk = ~clk;
  ysyx_22040632_mul_if mif ();
  ysyx_22040632_mul_iter dut (.clk(clk), .rst_n(rst_n), .bus(mif));
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  task automatic issue(input logic w, input logic [1:0] s, input logic [63:0] a, input logic [63:0] b);
    mif.mulw = w;
    mif.mul_signed = s;
    mif.multiplicand = a;
    mif.multiplier = b;
    mif.mul_valid = 1'b1;
  endtask
  task automatic wait_done(input string tag, input int lat, input logic [63:0] hi, input logic [63:0] lo);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
      mif.mul_valid = 1'b0;
    end while (!mif.out_valid && n < 200);
    chk({tag, "_lat"}, 64'(n), 64'(lat));
    chk({tag, "_hi"}, mif.result_hi, hi);
    chk({tag, "_lo"}, mif.result_lo, lo);
  endtask
  initial begin
    bit seen;
    mif.mul_valid = 1'b0;
    mif.flush = 1'b0;
    issue(1'b0, 2'b00, 64'd0, 64'd0);
    mif.mul_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_ready", 64'(mif.mul_ready), 64'd0);
    chk("rst_ov", 64'(mif.out_valid), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("init_ready", 64'(mif.mul_ready), 64'd1);
    chk("init_hi", mif.result_hi, 64'd0);
    chk("init_lo", mif.result_lo, 64'd0);
    issue(1'b0, 2'b11, '1, '1);
    wait_done("ss", 66, 64'h0, 64'h1);
    issue(1'b0, 2'b00, '1, '1);
    wait_done("uu", 66, 64'hFFFF_FFFF_FFFF_FFFE, 64'h1);
    issue(1'b0, 2'b10, 64'hFFFF_FFFF_FFFF_FFFE, '1);
    wait_done("su", 66, 64'hFFFF_FFFF_FFFF_FFFE, 64'h2);
    @(negedge clk);
    chk("pulse_ov", 64'(mif.out_valid), 64'd0);
    chk("hold_lo", mif.result_lo, 64'h2);
    issue(1'b1, 2'b11, 64'h7FFF_FFFF, 64'h2);
    wait_done("mulw", 34, 64'h0, 64'hFFFF_FFFF_FFFF_FFFE);
    issue(1'b0, 2'b00, 64'd4, 64'd4);
    mif.flush = 1'b1;
    @(negedge clk);
    chk("fdone_ov", 64'(mif.out_valid), 64'd0);
    chk("fdone_ready", 64'(mif.mul_ready), 64'd1);
    chk("fdone_lo", mif.result_lo, 64'hFFFF_FFFF_FFFF_FFFE);
    @(negedge clk);
    chk("fidle_ready", 64'(mif.mul_ready), 64'd1);
    mif.flush = 1'b0;
    mif.mul_valid = 1'b0;
    issue(1'b0, 2'b00, 64'd7, 64'd9);
    seen = 1'b0;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      mif.mul_valid = 1'b0;
      seen |= mif.out_valid;
    end
    mif.flush = 1'b1;
    @(negedge clk);
    chk("fbusy_ready", 64'(mif.mul_ready), 64'd1);
    chk("fbusy_ov", 64'(seen | mif.out_valid), 64'd0);
    mif.flush = 1'b0;
    issue(1'b0, 2'b00, 64'd3, 64'd5);
    wait_done("after_flush", 66, 64'h0, 64'd15);
    issue(1'b0, 2'b00, 64'h1_0000_0000, 64'h1_0000_0000);
    wait_done("b2b", 66, 64'h1, 64'h0);
    @(negedge clk);
    issue(1'b0, 2'b11, '1, 64'd3);
    repeat (20) @(negedge clk) mif.mul_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("mrst_ready", 64'(mif.mul_ready), 64'd0);
    chk("mrst_ov", 64'(mif.out_valid), 64'd0);
    chk("mrst_hi", mif.result_hi, 64'd0);
    chk("mrst_lo", mif.result_lo, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("mrst_rel_ready", 64'(mif.mul_ready), 64'd1);
    seen = 1'b0;
    repeat (80) begin
      @(negedge clk);
      seen |= mif.out_valid;
    end
    chk("mrst_no_ov", 64'(seen), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/ysyx_22040632_mul_iter.md
# ysyx_22040632_mul_iter

Iterative radix-2 shift-add multiplier implementing the multiplier-unit side of the CPU multiply channel. Accepts one 64×64 or 32×32 (mulw) multiply of selectable signedness from the EXU, produces the exact 128-bit product as hi/lo halves, and supports cancellation by flush. Adds the mul_ready/out_valid handshake so the EXU can stall on a variable-latency multiply.

## Interface
Parameters:
- XLEN, 64, operand width
- WXLEN, 32, mulw operand width

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- mul_valid  in  1  operands valid; deasserted the cycle after acceptance unless a new op is presented
- flush  in  1  cancel any in-flight multiply
- mulw  in  1  1 = 32-bit multiply
- mul_signed  in  2  2'b11 signed×signed, 2'b10 signed×unsigned, 2'b00 unsigned×unsigned (2'b01 treated as 2'b00)
- multiplicand  in  XLEN  multiplicand
- multiplier  in  XLEN  multiplier
- mul_ready  out  1  unit can accept an op this cycle
- out_valid  out  1  one-cycle pulse, result valid
- result_hi  out  XLEN  product[127:64] (0 for mulw)
- result_lo  out  XLEN  product[63:0]; for mulw, sign-extended product[31:0]

## Operation
- States: IDLE, BUSY, DONE.
- Accept = mul_valid && mul_ready && !flush. Operands latched on accept.
- Operand extension on accept: to 65 bits; signed operands sign-extend, unsigned zero-extend. mulw uses low 32 bits extended to 33 bits per mul_signed. Multiplicand sign = bit 64/32 of extended value.
- Iteration count N = 65 (64-bit) or 33 (mulw). Each BUSY cycle examines one multiplier bit LSB-first, adds the shifted multiplicand into a 66-bit accumulator (one guard bit), shifts accumulator/multiplier pair right arithmetically. Final iteration (multiplier sign bit) subtracts instead of adds.
- Transitions: IDLE -accept-> BUSY (cnt ← N-1); BUSY with cnt==0 -> DONE, else cnt--; DONE -accept-> BUSY, else -> IDLE.
- flush: any state -> IDLE next edge; no out_valid; flush with mul_valid in same cycle: op not accepted.
- mul_ready = (state==IDLE || state==DONE) && rst_n deasserted.
- out_valid = (state==DONE). result_hi/result_lo are registers updated only on entry to DONE, held until the next DONE entry; never change while out_valid high.
- Reset (any time, including mid-op): state IDLE, cnt 0, out_valid 0, mul_ready 1 after release, result_hi 0, result_lo 0, accumulators 0.

## Timing
- Accept on edge T → BUSY cycles T+1..T+N → out_valid high in cycle T+N+1 (66 cycles 64-bit, 34 mulw).
- Back-to-back: op accepted in DONE cycle; next out_valid exactly N+1 cycles later; no bubble.
- flush and DONE coincide: out_valid still high that cycle (already registered); state → IDLE.
- No combinational path from inputs to out_valid/result; mul_ready depends only on state.

## Structure
- Package ysyx_22040632_mul_pkg: state enum (IDLE/BUSY/DONE), mul_signed encodings (MUL_SS, MUL_SU, MUL_UU), XLEN/WXLEN, cycle-count constants N64=65, N32=33.
- One sub-module: ysyx_22040632_mul_opext (combinational operand extension for mulw/mul_signed, 65-bit outputs), instantiated twice.
- Top holds FSM, counter, accumulator/shift datapath, result formatting.

## Test plan
- SS, 64-bit, -1 × -1 → out_valid 66 cycles after accept; hi=0x0, lo=0x1.
- UU, 64-bit, 0xFFFF_FFFF_FFFF_FFFF × 0xFFFF_FFFF_FFFF_FFFF → hi=0xFFFF_FFFF_FFFF_FFFE, lo=0x1.
- SU, 64-bit, 0xFFFF_FFFF_FFFF_FFFE × 0xFFFF_FFFF_FFFF_FFFF → hi=0xFFFF_FFFF_FFFF_FFFE, lo=0x2.
- mulw SS, 0x7FFF_FFFF × 0x2 → out_valid 34 cycles after accept; lo=0xFFFF_FFFF_FFFF_FFFE, hi=0.
- Accept, flush in 10th BUSY cycle → no out_valid, mul_ready next cycle; new op 3×5 UU accepted next cycle → lo=15, hi=0 after 66 cycles; back-to-back second op accepted in DONE completes 66 cycles later.
- rst_n low mid-BUSY → all outputs 0, mul_ready 1 after release, no out_valid from old op.
